mem_port_ctrl: RTL
==================

# mem_port_ctrl

Memory-port controller between the multicycle RV32I datapath/control pair and the physical memory. The controller latches one CPU load/store request and holds a stable, word-aligned memory request until the memory responds. It generates byte enables from the access width and address low bits and returns a one-cycle response to the CPU. The datapath still performs store-lane shifting and load byte/half extraction; this block does not.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of ACCESS cycles without `mem_resp` before abort. Legal range 1..65535. Used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `cpu_read` in 1: load request, level, held by CPU until `cpu_resp`.
- `cpu_write` in 1: store request, level, held by CPU until `cpu_resp`.
- `cpu_addr` in 32: byte address (datapath MAR output).
- `cpu_wdata` in 32: store data, already lane-shifted by the datapath.
- `cpu_funct3` in 3: access width. `x00` = byte, `x01` = half, `x10` = word. Bit 2 (unsigned) is ignored here.
- `cpu_resp` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: load data, valid when `cpu_resp`=1, held until the next capture.
- `cpu_err` out 1: qualifies `cpu_resp`; 1 = misaligned access or timeout.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_address` out 32: `{cpu_addr[31:2], 2'b00}`, registered.
- `mem_wdata` out 32: registered store data.
- `mem_byte_enable` out 4: registered byte mask.
- `mem_rdata` in 32: memory read data.
- `mem_resp` in 1: memory completion, one cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - If `cpu_write` or `cpu_read` is asserted, capture the address, data, width and direction into registers.
  - If both are asserted, the write wins and the read is ignored.
  - Aligned access: go to ACCESS.
  - Misaligned access (half with `addr[0]`=1, or word with `addr[1:0]`≠0): set the error flag and go to RESP without touching memory.
- **Byte enables** (stores)
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
  - Reads always drive `4'b1111`.
- **ACCESS**
  - `mem_read` or `mem_write` is asserted from the registered direction.
  - Address, data and enable are stable for the whole state.
  - When `mem_resp`=1: capture `mem_rdata` into the rdata register (reads only; stores leave it unchanged) and go to RESP.
- **RESP**
  - `cpu_resp`=1 for exactly one cycle, with `cpu_err` equal to the error flag.
  - Next state is IDLE. The error flag clears on entry to IDLE.
- `mem_resp` in IDLE or RESP is ignored, for example a late response after a reset.
- Reset at any point, including mid-ACCESS:
  - All outputs are 0, and `mem_read`/`mem_write` drop asynchronously.
  - All registers clear, including `cpu_rdata`, `mem_address`, `mem_wdata` and `mem_byte_enable`.

## Timing
- Request seen in IDLE at edge 0. The memory strobe is asserted from edge 1 (registered).
- If `mem_resp` is sampled at edge k (k≥1), `cpu_resp` is high in the cycle after edge k.
- Minimum request-to-`cpu_resp` latency is 2 cycles with a 0-wait memory. A misaligned access also completes in 2 cycles (IDLE→RESP).
- At most one request is in flight. No new request is accepted in ACCESS or RESP.
- The CPU must drop its request the cycle after `cpu_resp`. IDLE re-samples on that cycle, and a still-held request is treated as a new one.
- All outputs are driven directly from registers or from state decode. There are no combinational input-to-output paths.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ACCESS and increments on each ACCESS cycle without `mem_resp`.
  - When the count equals `TIMEOUT_CYCLES` without a response, the strobes drop, the rdata register is cleared to 0, the error flag is set and the FSM goes to RESP.
  - If `mem_resp` arrives in the same cycle as the timeout, `mem_resp` wins and the access completes normally.
- `MEM_TIMEOUT_EN` undefined:
  - No counter exists, and ACCESS waits indefinitely.
  - `cpu_err` asserts only for misalignment, and `TIMEOUT_CYCLES` is unused.

## Test plan
- SW, `cpu_addr`=0x1000_0004, `cpu_wdata`=0xCAFEBABE, memory with 3 wait states -> `mem_address`=0x1000_0004, `mem_byte_enable`=4'hF, `mem_write` held 4 cycles, `cpu_resp`=1 and `cpu_err`=0 five cycles after the request.
- SB at 0x0000_0013, then SH at 0x0000_0012 -> `mem_address`=0x0000_0010 for both; byte enables 4'b1000, then 4'b1100.
- LW at 0x0000_0020 with 0-wait memory returning 0x1234_5678 -> `cpu_resp` 2 cycles after the request, `cpu_rdata`=0x1234_5678, held after `cpu_resp` falls.
- LW at 0x0000_0022, and SH at 0x0000_0001 -> no `mem_read`/`mem_write` ever asserted; `cpu_resp`=1 and `cpu_err`=1 two cycles after the request.
- `cpu_read` and `cpu_write` asserted together; separately, `rst` pulsed mid-ACCESS followed by a late `mem_resp` -> the simultaneous request produces a write only; after the reset all outputs are 0 immediately and the late `mem_resp` produces no `cpu_resp`.
- (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8) LW with memory that never responds -> the strobe drops after 8 ACCESS cycles; `cpu_resp`=1, `cpu_err`=1, `cpu_rdata`=0. With `mem_resp` arriving exactly at count 8, the access completes with `cpu_err`=0.

Source files
------------

// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// mem_port_ctrl : holds one CPU load/store as a stable word-aligned memory
//                 request and returns a one-cycle response with error flag.
// Optional feature macro: MEM_TIMEOUT_EN (abort stalled ACCESS after
//                 TIMEOUT_CYCLES cycles without mem_resp).
// Revision      : 1.0
// ============================================================================
module mem_port_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [2:0]  cpu_funct3_i,
    output logic        cpu_resp_o,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_err_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_byte_enable_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_resp_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("mem_port_ctrl: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q,    be_d;
    logic        write_q, write_d;
    logic        err_q,   err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_req;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic        w_unused_funct3;

    // Bit 2 only selects sign extension, which the datapath performs.
    assign w_unused_funct3 = cpu_funct3_i[2];
    assign w_req           = cpu_read_i | cpu_write_i;

    always_comb begin
        w_misaligned = 1'b0;
        case (cpu_funct3_i[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = cpu_addr_i[0];
            default: w_misaligned = (cpu_addr_i[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        w_be = 4'hF;
        if (cpu_write_i) begin
            case (cpu_funct3_i[1:0])
                2'b00:   w_be = 4'b0001 << cpu_addr_i[1:0];
                2'b01:   w_be = 4'b0011 << cpu_addr_i[1:0];
                default: w_be = 4'hF;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] w_cnt_next;
    assign w_cnt_next = cnt_q + 16'd1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (w_req) begin
                    // A simultaneous read and write is treated as a write.
                    addr_d  = {cpu_addr_i[31:2], 2'b00};
                    wdata_d = cpu_wdata_i;
                    be_d    = w_be;
                    write_d = cpu_write_i;
                    err_d   = w_misaligned;
                    state_d = w_misaligned ? S_RESP : S_ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 16'd0;
`endif
                end
            end
            S_ACCESS: begin
                if (mem_resp_i) begin
                    if (!write_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = S_RESP;
`ifdef MEM_TIMEOUT_EN
                end else begin
                    cnt_d = w_cnt_next;
                    if (w_cnt_next == c_TIMEOUT) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Strobes decode the async-reset state register, so they drop with rst.
    assign mem_read_o        = (state_q == S_ACCESS) & ~write_q;
    assign mem_write_o       = (state_q == S_ACCESS) &  write_q;
    assign mem_address_o     = addr_q;
    assign mem_wdata_o       = wdata_q;
    assign mem_byte_enable_o = be_q;
    assign cpu_resp_o        = (state_q == S_RESP);
    assign cpu_err_o         = (state_q == S_RESP) & err_q;
    assign cpu_rdata_o       = rdata_q;

endmodule
`default_nettype wire
